sd_access_arbiter: RTL and testbench

- Shares one SD card SPI controller (512-byte sector read/write engine) between NUM_REQ requesters, e.g. CPU loader and framebuffer streamer.
- Grants one requester at a time in round-robin order and issues that requester's sector command.
- Routes the byte stream between the granted requester and the controller, counts bytes, and reports completion.
- Enforces sector alignment and a watchdog; on watchdog expiry, resets the controller.

---
 rtl/sd_access_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_sd_access_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_access_arbiter.sv
// Round-robin arbiter sharing one SD card sector engine between NUM_REQ requesters.
// Issues the owner's sector command, routes bytes, counts them and supervises with a watchdog.
module sd_access_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16777216,
    parameter int SECTOR_BYTES   = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [32*NUM_REQ-1:0]   req_address,
    input  logic [8*NUM_REQ-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic [NUM_REQ-1:0]      req_rvalid,
    output logic [NUM_REQ-1:0]      req_wnext,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_error,
    output logic [7:0]              rdata,
    output logic                    busy,
    input  logic                    sd_ready,
    output logic                    sd_rd,
    output logic                    sd_wr,
    output logic [31:0]             sd_address,
    input  logic [7:0]              sd_dout,
    input  logic                    sd_byte_available,
    output logic [7:0]              sd_din,
    input  logic                    sd_ready_for_next_byte,
    output logic                    sd_reset
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_XFER, S_FINISH, S_ABORT} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d, owner_q, owner_d;
    logic                 wr_q, wr_d;
    logic [31:0]          addr_q, addr_d;
    logic [9:0]           cnt_q, cnt_d;
    logic [31:0]          wd_q, wd_d;
    logic                 bav_q, rfn_q;
    logic [7:0]           rdata_q, rdata_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d, rvalid_q, rvalid_d, wnext_q, wnext_d;
    logic [NUM_REQ-1:0]   done_q, done_d, error_q, error_d;
    logic                 sdrst_q, sdrst_d, ab_q, ab_d;
    logic                 bav_rise, rfn_rise, found;
    logic [IW-1:0]        pick;
    int                   idx;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NUM_REQ-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] c);
        return (c == 10'h3FF) ? c : c + 10'd1;
    endfunction

    assign bav_rise = sd_byte_available & ~bav_q;
    assign rfn_rise = sd_ready_for_next_byte & ~rfn_q;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        rdata_d  = rdata_q;
        grant_d  = grant_q;
        rvalid_d = '0;
        wnext_d  = '0;
        done_d   = '0;
        error_d  = '0;
        sdrst_d  = 1'b0;
        ab_d     = 1'b0;
        found    = 1'b0;
        pick     = '0;
        idx      = 0;
        case (state_q)
            S_IDLE: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (int'(rr_q) + k) % NUM_REQ;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        pick  = IW'(idx);
                    end
                end
                if (sd_ready && found) begin
                    owner_d = pick;
                    wr_d    = req_write[pick];
                    addr_d  = req_address[32*pick +: 32];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (addr_q[8:0] != 9'd0) begin
                    error_d = onehot(owner_q);
                    rr_d    = next_idx(owner_q);
                    state_d = S_IDLE;
                end else begin
                    grant_d = onehot(owner_q);
                    cnt_d   = '0;
                    wd_d    = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE, S_XFER: begin
                wd_d = wd_q + 32'd1;
                if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    grant_d = '0;
                    error_d = onehot(owner_q);
                    sdrst_d = 1'b1;
                    state_d = S_ABORT;
                end else if (state_q == S_ISSUE) begin
                    if (!sd_ready) state_d = S_XFER;
                end else begin
                    // Strobes are counted before sd_ready is judged so a final byte coinciding with the return of ready is kept.
                    if (!wr_q && bav_rise) begin
                        rdata_d  = sd_dout;
                        rvalid_d = onehot(owner_q);
                        cnt_d    = sat_inc(cnt_q);
                    end
                    if (wr_q && rfn_rise) begin
                        wnext_d = onehot(owner_q);
                        cnt_d   = sat_inc(cnt_q);
                    end
                    if (sd_ready) begin
                        grant_d = '0;
                        state_d = S_FINISH;
                        if (wr_q || int'(cnt_d) == SECTOR_BYTES) done_d  = onehot(owner_q);
                        else                                     error_d = onehot(owner_q);
                    end
                end
            end
            S_FINISH: begin
                rr_d    = next_idx(owner_q);
                state_d = S_IDLE;
            end
            S_ABORT: begin
                if (!ab_q) begin
                    sdrst_d = 1'b1;
                    ab_d    = 1'b1;
                end else begin
                    rr_d    = next_idx(owner_q);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            wd_q     <= '0;
            bav_q    <= 1'b0;
            rfn_q    <= 1'b0;
            rdata_q  <= '0;
            grant_q  <= '0;
            rvalid_q <= '0;
            wnext_q  <= '0;
            done_q   <= '0;
            error_q  <= '0;
            sdrst_q  <= 1'b0;
            ab_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            bav_q    <= sd_byte_available;
            rfn_q    <= sd_ready_for_next_byte;
            rdata_q  <= rdata_d;
            grant_q  <= grant_d;
            rvalid_q <= rvalid_d;
            wnext_q  <= wnext_d;
            done_q   <= done_d;
            error_q  <= error_d;
            sdrst_q  <= sdrst_d;
            ab_q     <= ab_d;
        end
    end

    assign req_grant  = grant_q;
    assign req_rvalid = rvalid_q;
    assign req_wnext  = wnext_q;
    assign req_done   = done_q;
    assign req_error  = error_q;
    assign rdata      = rdata_q;
    assign busy       = (state_q != S_IDLE);
    assign sd_rd      = (state_q == S_ISSUE) & ~wr_q;
    assign sd_wr      = (state_q == S_ISSUE) & wr_q;
    assign sd_address = (|grant_q) ? addr_q : 32'd0;
    assign sd_din     = (|grant_q) ? req_wdata[8*owner_q +: 8] : 8'd0;
    assign sd_reset   = sdrst_q;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Directed bench for sd_access_arbiter with a behavioural SD controller and requesters.
module tb_sd_access_arbiter;
    localparam int NREQ = 2;
    localparam int TMO  = 2000;
    localparam int SB   = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_write;
    logic [63:0] req_address;
    logic [15:0] req_wdata;
    logic [1:0]  req_grant, req_rvalid, req_wnext, req_done, req_error;
    logic [7:0]  rdata;
    logic        busy;
    logic        sd_ready, sd_rd, sd_wr;
    logic [31:0] sd_address;
    logic [7:0]  sd_dout, sd_din;
    logic        sd_byte_available, sd_ready_for_next_byte, sd_reset;

    int n_tests = 0;
    int n_fail  = 0;
    int rv_cnt [2];
    int wn_cnt [2];
    int done_cnt [2];
    int err_cnt [2];
    logic [7:0] rd_exp [2];
    int rd_bad, din_bad, srst_cnt, onehot_bad, order_n, k, base_n;
    int order_log [8];
    bit rdwr_seen;
    logic [1:0] prev_grant;
    logic [3:0] fin;

    always #5 clk = ~clk;

    sd_access_arbiter #(
        .NUM_REQ(NREQ),
        .TIMEOUT_CYCLES(TMO),
        .SECTOR_BYTES(SB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_address(req_address),
        .req_wdata(req_wdata),
        .req_grant(req_grant),
        .req_rvalid(req_rvalid),
        .req_wnext(req_wnext),
        .req_done(req_done),
        .req_error(req_error),
        .rdata(rdata),
        .busy(busy),
        .sd_ready(sd_ready),
        .sd_rd(sd_rd),
        .sd_wr(sd_wr),
        .sd_address(sd_address),
        .sd_dout(sd_dout),
        .sd_byte_available(sd_byte_available),
        .sd_din(sd_din),
        .sd_ready_for_next_byte(sd_ready_for_next_byte),
        .sd_reset(sd_reset)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of observation plus requester-side behaviour.
    task automatic tick();
        @(negedge clk);
        for (int p = 0; p < NREQ; p++) begin
            if (req_rvalid[p]) begin
                if (rdata !== rd_exp[p]) rd_bad++;
                rd_exp[p] = rd_exp[p] + 8'd1;
                rv_cnt[p]++;
            end
            if (req_wnext[p]) begin
                wn_cnt[p]++;
                req_wdata[8*p +: 8] = req_wdata[8*p +: 8] + 8'd1;
            end
            if (req_done[p])  done_cnt[p]++;
            if (req_error[p]) err_cnt[p]++;
        end
        if (sd_reset) srst_cnt++;
        if (sd_rd | sd_wr) rdwr_seen = 1'b1;
        if ($countones(req_grant) > 1) onehot_bad++;
        if (req_grant != 2'b00 && prev_grant == 2'b00 && order_n < 8) begin
            order_log[order_n] = req_grant[1] ? 1 : 0;
            order_n++;
        end
        prev_grant = req_grant;
        req_valid  = req_valid & ~req_grant & ~req_error;
    endtask

    // Behavioural SD controller: one sector command, nbytes strobes, then ready again.
    task automatic sd_serve(input int nbytes, input bit is_wr, input bit merge_last,
                            input logic [7:0] wbase, output logic [3:0] f);
        int w;
        logic [7:0] wexp;
        f = 4'b0;
        w = 0;
        while (!(sd_rd | sd_wr) && w < 20) begin
            tick();
            w++;
        end
        check_eq("issue_seen", 64'(sd_rd | sd_wr), 64'd1);
        check_eq("issue_dir", 64'(sd_wr), 64'(is_wr));
        sd_ready = 1'b0;
        tick();
        wexp = wbase;
        for (int i = 0; i < nbytes; i++) begin
            if (is_wr) begin
                if (sd_din !== wexp) din_bad++;
                wexp = wexp + 8'd1;
                sd_ready_for_next_byte = 1'b1;
                tick();
                sd_ready_for_next_byte = 1'b0;
                tick();
            end else begin
                sd_dout = 8'(i);
                sd_byte_available = 1'b1;
                if (merge_last && i == nbytes - 1) sd_ready = 1'b1;
                tick();
                if (merge_last && i == nbytes - 1) f = {req_done, req_error};
                sd_byte_available = 1'b0;
                tick();
            end
        end
        if (!sd_ready) begin
            sd_ready = 1'b1;
            tick();
            f = {req_done, req_error};
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0;
        sd_ready = 1'b1; sd_dout = '0; sd_byte_available = 1'b0; sd_ready_for_next_byte = 1'b0;
        for (int p = 0; p < NREQ; p++) begin
            rv_cnt[p] = 0; wn_cnt[p] = 0; done_cnt[p] = 0; err_cnt[p] = 0; rd_exp[p] = 8'd0;
        end
        rd_bad = 0; din_bad = 0; srst_cnt = 0; onehot_bad = 0; order_n = 0; rdwr_seen = 1'b0;
        prev_grant = '0;
        for (int i = 0; i < 8; i++) order_log[i] = -1;

        repeat (3) tick();
        check_eq("rst_outs", 64'({req_grant, req_rvalid, req_wnext, req_done, req_error, rdata,
                                  busy, sd_rd, sd_wr, sd_address, sd_din, sd_reset}), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Contention, two rounds of short writes: round-robin 0,1,0,1
        for (int r = 0; r < 2; r++) begin
            req_write = 2'b11; req_address = {32'h0000_2000, 32'h0000_1000};
            req_wdata = {8'h50, 8'h10}; req_valid = 2'b11;
            sd_serve(4, 1'b1, 1'b0, 8'h10, fin);
            check_eq("cont_done0", 64'(fin), 64'b0100);
            sd_serve(4, 1'b1, 1'b0, 8'h50, fin);
            check_eq("cont_done1", 64'(fin), 64'b1000);
        end
        check_eq("rr_order0", 64'(order_log[0]), 64'd0);
        check_eq("rr_order1", 64'(order_log[1]), 64'd1);
        check_eq("rr_order2", 64'(order_log[2]), 64'd0);
        check_eq("rr_order3", 64'(order_log[3]), 64'd1);
        check_eq("cont_wnext", 64'({wn_cnt[0][15:0], wn_cnt[1][15:0]}), 64'h0008_0008);
        check_eq("cont_din", 64'(din_bad), 64'd0);

        // Single full read on port 0, last strobe coincident with ready return
        req_write = 2'b00; req_address = {32'h0, 32'h0000_0400}; req_valid = 2'b01;
        rd_exp[0] = 8'd0; rv_cnt[0] = 0;
        tick();
        check_eq("rd_grant_c1", 64'(req_grant), 64'd0);
        tick();
        check_eq("rd_grant_c2", 64'(req_grant), 64'b01);
        check_eq("rd_sd_rd", 64'(sd_rd), 64'd1);
        check_eq("rd_address", 64'(sd_address), 64'h400);
        sd_serve(SB, 1'b0, 1'b1, 8'h00, fin);
        check_eq("rd_done_lat", 64'(fin), 64'b0100);
        check_eq("rd_rvalid_cnt", 64'(rv_cnt[0]), 64'd512);
        check_eq("rd_data", 64'(rd_bad), 64'd0);
        check_eq("rd_done_cnt", 64'(done_cnt[0]), 64'd3);
        check_eq("rd_busy_end", 64'(busy), 64'd0);

        // Misaligned request on port 1
        rdwr_seen = 1'b0; base_n = order_n;
        req_address = {32'h0000_0201, 32'h0}; req_valid = 2'b10;
        tick();
        check_eq("mis_err_c1", 64'(req_error), 64'd0);
        tick();
        check_eq("mis_err_c2", 64'(req_error), 64'b10);
        repeat (4) tick();
        check_eq("mis_no_cmd", 64'(rdwr_seen), 64'd0);
        check_eq("mis_no_grant", 64'(order_n), 64'(base_n));
        check_eq("mis_busy", 64'(busy), 64'd0);

        // Write of 8 bytes on port 1: completes with no count check
        wn_cnt[1] = 0; din_bad = 0;
        req_write = 2'b10; req_address = {32'h0000_0800, 32'h0}; req_wdata = {8'hC0, 8'h00};
        req_valid = 2'b10;
        sd_serve(8, 1'b1, 1'b0, 8'hC0, fin);
        check_eq("wr_done", 64'(fin), 64'b1000);
        check_eq("wr_wnext_cnt", 64'(wn_cnt[1]), 64'd8);
        check_eq("wr_din", 64'(din_bad), 64'd0);

        // Short read, 511 bytes on port 0
        rd_exp[0] = 8'd0; rv_cnt[0] = 0;
        req_write = 2'b00; req_address = {32'h0, 32'h0000_0C00}; req_valid = 2'b01;
        sd_serve(SB - 1, 1'b0, 1'b0, 8'h00, fin);
        check_eq("short_err", 64'(fin), 64'b0001);
        check_eq("short_rv_cnt", 64'(rv_cnt[0]), 64'd511);
        check_eq("short_done_cnt", 64'(done_cnt[0]), 64'd3);

        // Watchdog: controller never returns ready
        srst_cnt = 0; err_cnt[0] = 0;
        req_address = {32'h0, 32'h0000_0E00}; req_valid = 2'b01;
        tick();
        tick();
        check_eq("tmo_grant", 64'(req_grant), 64'b01);
        sd_ready = 1'b0;
        k = 0;
        while (req_error == 2'b00 && k < TMO + 100) begin
            tick();
            k++;
        end
        check_eq("tmo_cycles", 64'(k), 64'(TMO));
        check_eq("tmo_err_bit", 64'(req_error), 64'b01);
        repeat (4) tick();
        check_eq("tmo_sd_reset", 64'(srst_cnt), 64'd2);
        check_eq("tmo_grant_off", 64'(req_grant), 64'd0);
        check_eq("tmo_busy_off", 64'(busy), 64'd0);
        check_eq("tmo_err_cnt", 64'(err_cnt[0]), 64'd1);
        sd_ready = 1'b1;
        tick();

        // Asynchronous reset in the middle of a read, then a normal read on port 1
        req_address = {32'h0, 32'h0000_0600}; req_valid = 2'b01;
        k = 0;
        while (!sd_rd && k < 20) begin
            tick();
            k++;
        end
        sd_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            sd_dout = 8'(i); sd_byte_available = 1'b1; tick();
            sd_byte_available = 1'b0; tick();
        end
        check_eq("arst_pre_busy", 64'({busy, req_grant}), 64'b101);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_outs", 64'({req_grant, req_rvalid, req_wnext, req_done, req_error, rdata,
                                   busy, sd_rd, sd_wr, sd_address, sd_din, sd_reset}), 64'd0);
        tick();
        reset = 1'b1; sd_ready = 1'b1;
        tick();
        rd_exp[1] = 8'd0; rv_cnt[1] = 0; rd_bad = 0;
        req_address = {32'h0000_0A00, 32'h0}; req_valid = 2'b10;
        sd_serve(SB, 1'b0, 1'b0, 8'h00, fin);
        check_eq("post_rst_done", 64'(fin), 64'b1000);
        check_eq("post_rst_rv", 64'(rv_cnt[1]), 64'd512);
        check_eq("post_rst_data", 64'(rd_bad), 64'd0);
        check_eq("grant_onehot", 64'(onehot_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
